// File: rtl/adder.sv
// Two-operand adder with carry-in/carry-out and signed overflow.
// The sum is formed through a blocked carry-lookahead network (GROUP_W-bit
// groups, the last group may be narrower) and registered once; the result
// registers only load on valid cycles so they hold the last result otherwise.
module adder #(
    parameter int DATA_WIDTH = 20,
    parameter int GROUP_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  out_valid
);

    localparam int NG = (DATA_WIDTH + GROUP_W - 1) / GROUP_W;

    logic [DATA_WIDTH-1:0] bit_g;
    logic [DATA_WIDTH-1:0] bit_p;
    logic [DATA_WIDTH-1:0] bit_c;
    logic [NG-1:0]         grp_g;
    logic [NG-1:0]         grp_p;
    logic [NG:0]           grp_c;

    logic [DATA_WIDTH-1:0] sum_d;
    logic                  carry_d;
    logic                  overflow_d;

    logic [DATA_WIDTH-1:0] sum_q;
    logic                  carry_q;
    logic                  overflow_q;
    logic                  valid_q;

    // Per-bit generate/propagate.
    always_comb begin
        bit_g = a & b;
        bit_p = a ^ b;
    end

    // Group generate/propagate, folded from the group LSB upward.
    always_comb begin
        grp_g = '0;
        grp_p = '1;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GROUP_W; j++) begin
                if (k * GROUP_W + j < DATA_WIDTH) begin
                    grp_g[k] = bit_g[k*GROUP_W+j] | (bit_p[k*GROUP_W+j] & grp_g[k]);
                    grp_p[k] = grp_p[k] & bit_p[k*GROUP_W+j];
                end
            end
        end
    end

    // Lookahead carries between groups; grp_c[NG] is the carry out of the MSB.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = carry_in;
        for (int k = 0; k < NG; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
    end

    // Carries into each bit, rippled inside a group from its lookahead carry.
    always_comb begin
        logic c;
        c     = 1'b0;
        bit_c = '0;
        for (int k = 0; k < NG; k++) begin
            c = grp_c[k];
            for (int j = 0; j < GROUP_W; j++) begin
                if (k * GROUP_W + j < DATA_WIDTH) begin
                    bit_c[k*GROUP_W+j] = c;
                    c = bit_g[k*GROUP_W+j] | (bit_p[k*GROUP_W+j] & c);
                end
            end
        end
    end

    // Sum bits, carry out and signed overflow of the combinational result.
    always_comb begin
        sum_d      = bit_p ^ bit_c;
        carry_d    = grp_c[NG];
        overflow_d = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                     (sum_d[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
    end

    // Output registers: reset wins, results load only on valid cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q      <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q      <= sum_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign overflow  = overflow_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_adder.sv
// Bench for adder: directed boundary cases, back-to-back ops, reset during an
// active op, and random vectors on 20-, 7- and 1-bit builds against plain
// arithmetic.
module tb_adder;

    logic clk;
    logic rst_n;
    logic in_valid;

    logic [19:0] a20, b20, sum20;
    logic        cin20, cout20, ovf20, vld20;
    logic [6:0]  a7, b7, sum7;
    logic        cin7, cout7, ovf7, vld7;
    logic [0:0]  a1, b1, sum1;
    logic        cin1, cout1, ovf1, vld1;

    int total = 0;
    int bad   = 0;

    adder #(.DATA_WIDTH(20), .GROUP_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a20), .b(b20), .carry_in(cin20),
        .sum(sum20), .carry_out(cout20), .overflow(ovf20), .out_valid(vld20)
    );

    adder #(.DATA_WIDTH(7), .GROUP_W(4)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a7), .b(b7), .carry_in(cin7),
        .sum(sum7), .carry_out(cout7), .overflow(ovf7), .out_valid(vld7)
    );

    adder #(.DATA_WIDTH(1), .GROUP_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .carry_in(cin1),
        .sum(sum1), .carry_out(cout1), .overflow(ovf1), .out_valid(vld1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact (W+1)-bit sum; overflow when operand signs agree
    // but the result sign differs. Returned as {ovf, cout, sum}.
    function automatic logic [21:0] ref20(input logic [19:0] x, input logic [19:0] y,
                                          input logic ci);
        logic [20:0] s;
        logic        o;
        s = {1'b0, x} + {1'b0, y} + {20'd0, ci};
        o = (x[19] == y[19]) && (s[19] != x[19]);
        return {o, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive20(input logic [19:0] x, input logic [19:0] y, input logic ci,
                           input logic v);
        a20 = x; b20 = y; cin20 = ci; in_valid = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive20(20'h12345, 20'h54321, 1'b1, 1'b1);
        tick();
        tick();
        total++;
        if ({sum20, cout20, ovf20, vld20} !== 23'd0) begin
            bad++;
            $display("FAIL reset: got sum=%h cout=%b ovf=%b vld=%b want all 0",
                     sum20, cout20, ovf20, vld20);
        end
        rst_n = 1'b1;
        drive20(20'h0, 20'h0, 1'b0, 1'b0);
        tick();
        total++;
        if ({sum20, cout20, ovf20, vld20} !== 23'd0) begin
            bad++;
            $display("FAIL reset_idle: got sum=%h cout=%b ovf=%b vld=%b want all 0",
                     sum20, cout20, ovf20, vld20);
        end
    endtask

    task automatic test_directed();
        logic [19:0] da [5];
        logic [19:0] db [5];
        logic        dc [5];
        logic [21:0] want [5];
        da[0] = 20'hAAAAA; db[0] = 20'h55555; dc[0] = 1'b0; want[0] = {1'b0, 1'b0, 20'hFFFFF};
        da[1] = 20'hFFFFF; db[1] = 20'h00001; dc[1] = 1'b1; want[1] = {1'b0, 1'b1, 20'h00001};
        da[2] = 20'h7FFFF; db[2] = 20'h00001; dc[2] = 1'b0; want[2] = {1'b1, 1'b0, 20'h80000};
        da[3] = 20'h80000; db[3] = 20'h80000; dc[3] = 1'b0; want[3] = {1'b1, 1'b1, 20'h00000};
        da[4] = 20'hFFFFF; db[4] = 20'h00000; dc[4] = 1'b1; want[4] = {1'b0, 1'b1, 20'h00000};
        for (int i = 0; i < 5; i++) begin
            drive20(da[i], db[i], dc[i], 1'b1);
            tick();
            total++;
            if ({ovf20, cout20, sum20} !== want[i] || vld20 !== 1'b1) begin
                bad++;
                $display("FAIL directed_%0d: got ovf=%b cout=%b sum=%h vld=%b want ovf=%b cout=%b sum=%h vld=1",
                         i, ovf20, cout20, sum20, vld20, want[i][21], want[i][20], want[i][19:0]);
            end
        end
        drive20(20'h0, 20'h0, 1'b0, 1'b1);
        tick();
        total++;
        if ({ovf20, cout20, sum20} !== 22'd0) begin
            bad++;
            $display("FAIL zero_add: got ovf=%b cout=%b sum=%h want 0", ovf20, cout20, sum20);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] xa [3];
        logic [19:0] xb [3];
        logic        xc [3];
        logic [21:0] last;
        for (int i = 0; i < 3; i++) begin
            xa[i] = 20'($urandom);
            xb[i] = 20'($urandom);
            xc[i] = 1'($urandom);
        end
        drive20(xa[0], xb[0], xc[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) drive20(xa[i+1], xb[i+1], xc[i+1], 1'b1);
            else       drive20(20'hFFFFF, 20'hFFFFF, 1'b1, 1'b0);
            last = ref20(xa[i], xb[i], xc[i]);
            total++;
            if ({ovf20, cout20, sum20} !== last || vld20 !== 1'b1) begin
                bad++;
                $display("FAIL b2b_%0d: got {ovf,cout,sum}=%h vld=%b want %h vld=1",
                         i, {ovf20, cout20, sum20}, vld20, last);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({ovf20, cout20, sum20} !== last || vld20 !== 1'b0) begin
                bad++;
                $display("FAIL b2b_hold_%0d: got {ovf,cout,sum}=%h vld=%b want %h vld=0",
                         i, {ovf20, cout20, sum20}, vld20, last);
            end
        end
    endtask

    task automatic test_reset_during_valid();
        drive20(20'h12345, 20'h11111, 1'b0, 1'b1);
        tick();
        rst_n = 1'b0;
        drive20(20'hFFFFF, 20'h00001, 1'b0, 1'b1);
        tick();
        total++;
        if ({sum20, cout20, ovf20, vld20} !== 23'd0) begin
            bad++;
            $display("FAIL rst_valid: got sum=%h cout=%b ovf=%b vld=%b want all 0",
                     sum20, cout20, ovf20, vld20);
        end
        rst_n = 1'b1;
        drive20(20'h0, 20'h0, 1'b0, 1'b0);
        tick();
        total++;
        if ({sum20, cout20, ovf20, vld20} !== 23'd0) begin
            bad++;
            $display("FAIL rst_discard: got sum=%h cout=%b ovf=%b vld=%b want all 0",
                     sum20, cout20, ovf20, vld20);
        end
    endtask

    task automatic test_random();
        logic [21:0] m20;
        logic [8:0]  m7;
        logic [2:0]  m1;
        logic [7:0]  s7;
        logic [1:0]  s1;
        logic        v;
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        m20 = '0; m7 = '0; m1 = '0;
        for (int n = 0; n < 10000; n++) begin
            v = ($urandom_range(0, 9) != 0);
            drive20(20'($urandom), 20'($urandom), 1'($urandom), v);
            a7 = 7'($urandom); b7 = 7'($urandom); cin7 = 1'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            if (v) begin
                m20 = ref20(a20, b20, cin20);
                s7  = {1'b0, a7} + {1'b0, b7} + {7'd0, cin7};
                m7  = {(a7[6] == b7[6]) && (s7[6] != a7[6]), s7};
                s1  = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
                m1  = {(a1[0] == b1[0]) && (s1[0] != a1[0]), s1};
            end
            tick();
            total++;
            if ({ovf20, cout20, sum20} !== m20 || vld20 !== v) begin
                bad++;
                $display("FAIL rand20_%0d: got {ovf,cout,sum}=%h vld=%b want %h vld=%b",
                         n, {ovf20, cout20, sum20}, vld20, m20, v);
            end
            total++;
            if ({ovf7, cout7, sum7} !== m7 || vld7 !== v) begin
                bad++;
                $display("FAIL rand7_%0d: got {ovf,cout,sum}=%h vld=%b want %h vld=%b",
                         n, {ovf7, cout7, sum7}, vld7, m7, v);
            end
            total++;
            if ({ovf1, cout1, sum1} !== m1 || vld1 !== v) begin
                bad++;
                $display("FAIL rand1_%0d: got {ovf,cout,sum}=%b vld=%b want %b vld=%b",
                         n, {ovf1, cout1, sum1}, vld1, m1, v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0;
        a20 = '0; b20 = '0; cin20 = 1'b0;
        a7 = '0; b7 = '0; cin7 = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_during_valid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
